// File: rtl/ef_smsdac_mse_p.sv
// ============================================================================
// ef_smsdac_mse_p
// ----------------------------------------------------------------------------
// Segmented mismatch-shaping encoder for a binary-weighted 3-level DAC array.
// A W-bit unsigned sample is split into S shaped 3-level LSB segments
// (segment i has weight 2^i) plus a binary coarse word of weight 2^S.
// Each segment keeps one bit of first-order state so that odd residues
// alternate between +1 and -1, pushing element mismatch error out of band.
// ms_en=0 selects plain binary (every odd residue encoded as +1, state frozen).
//
// Pipeline: stage 1 captures the sample on in_valid, stage 2 encodes and
// registers the outputs, so out_valid follows in_valid by two clocks.
//
// Optional build macro: EF_SMSDAC_DITHER_EN
//   defined   : a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) adds random
//               state toggles on even residues when en_dith=1 and ms_en=1.
//   undefined : no LFSR; en_dith is captured but has no effect.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   d_in      W-bit unsigned input sample
//   in_valid  capture strobe for d_in, ms_en, en_dith
//   ms_en     1 = mismatch shaping, 0 = binary bypass
//   en_dith   dither enable (only with EF_SMSDAC_DITHER_EN)
//   d_seg     segment codes, segment i at [2i+1:2i]: 01=+1, 10=-1, 00=0
//   d_msb     coarse binary word (W-S+1 bits), weight 2^S
//   out_valid one-cycle strobe marking updated d_seg/d_msb
// ============================================================================
module ef_smsdac_mse_p #(
    parameter int W = 8,
    parameter int S = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     d_in,
    input  logic             in_valid,
    input  logic             ms_en,
    input  logic             en_dith,
    output logic [2*S-1:0]   d_seg,
    output logic [W-S:0]     d_msb,
    output logic             out_valid
);

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    logic [W-1:0]   capData_q;
    logic           capMs_q;
    logic           capDith_q;
    logic           capValid_q;

    logic [2*S-1:0] seg_q, seg_d;
    logic [W-S:0]   msb_q, msb_d;
    logic           outValid_q;
    logic [S-1:0]   state_q, state_d;

    logic [W:0]     encVal;
    logic [S-1:0]   rBits;
    logic           dithAct;

`ifdef EF_SMSDAC_DITHER_EN
    logic [15:0] lfsr_q;
    logic        lfsrFb;

    // Dither only makes sense while shaping is on.
    assign dithAct = capDith_q & capMs_q;

    assign lfsrFb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Segment i draws its dither bit from LFSR tap (i mod 16).
    always_comb begin
        rBits = '0;
        for (int i = 0; i < S; i++) begin
            rBits[i] = lfsr_q[i % 16];
        end
    end

    // The LFSR advances once per encoded sample that actually used dither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (capValid_q && dithAct) begin
            lfsr_q <= {lfsr_q[14:0], lfsrFb};
        end
    end
`else
    // No dither hardware: the captured enable is kept but can never activate.
    assign dithAct = capDith_q & 1'b0;
    assign rBits   = '0;
`endif

    // Stage 1: capture the sample and its mode bits; the flag marks a fresh
    // sample for the encoder on the next clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capData_q  <= '0;
            capMs_q    <= 1'b0;
            capDith_q  <= 1'b0;
            capValid_q <= 1'b0;
        end else if (in_valid) begin
            capData_q  <= d_in;
            capMs_q    <= ms_en;
            capDith_q  <= en_dith;
            capValid_q <= 1'b1;
        end else begin
            capValid_q <= 1'b0;
        end
    end

    // Segment peel-off: each stage removes the LSB of the running residue as
    // +1 or -1 (chosen by the segment state) and halves what is left. Choosing
    // -1 rounds the residue up, which is why it needs one bit above W.
    always_comb begin
        encVal  = {1'b0, capData_q};
        seg_d   = '0;
        state_d = state_q;
        for (int i = 0; i < S; i++) begin
            if (encVal[0]) begin
                if (!capMs_q || !state_q[i]) begin
                    seg_d[2*i +: 2] = 2'b01;
                    encVal = (encVal - ONE) >> 1;
                end else begin
                    seg_d[2*i +: 2] = 2'b10;
                    encVal = (encVal + ONE) >> 1;
                end
                if (capMs_q) begin
                    state_d[i] = ~state_q[i];
                end
            end else begin
                encVal = encVal >> 1;
                if (dithAct && rBits[i]) begin
                    state_d[i] = ~state_q[i];
                end
            end
        end
        msb_d = encVal[W-S:0];
    end

    // Stage 2: register the encoded word and commit state only for a fresh
    // sample; otherwise everything holds and the strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q      <= '0;
            msb_q      <= '0;
            state_q    <= '0;
            outValid_q <= 1'b0;
        end else if (capValid_q) begin
            seg_q      <= seg_d;
            msb_q      <= msb_d;
            state_q    <= state_d;
            outValid_q <= 1'b1;
        end else begin
            outValid_q <= 1'b0;
        end
    end

    assign d_seg     = seg_q;
    assign d_msb     = msb_q;
    assign out_valid = outValid_q;

endmodule

// File: doc/ef_smsdac_mse_p.md
Name: ef_smsdac_mse_p

Overview:
Parametrised segmented mismatch-shaping encoder with a built-in input/output pipeline and valid handshake. It splits a W-bit unsigned sample into S shaped 3-level LSB segments plus a binary coarse word, each segment feeding a 2^i-weighted 3-level DAC. Per-segment first-order state, an optional dither LFSR, and a binary bypass mode are included. It sits between the data source and the DAC drivers, replacing the fixed-width sync, encoder and retiming chain.

Parameters:
W, 8, input sample width (bits), W >= 2
S, 3, number of shaped LSB segments, 1 <= S <= W-1

Ports:
clk  input  1  clock, 1-50 MHz
rst  input  1  asynchronous, active-high reset
d_in  input  W  unsigned sample
in_valid  input  1  capture strobe for d_in, ms_en and en_dith
ms_en  input  1  1 = mismatch shaping, 0 = binary bypass
en_dith  input  1  dither enable (effective only with macro)
d_seg  output  2*S  segment i code at [2i+1:2i]: 01 = +1, 10 = -1, 00 = 0; 11 never driven
d_msb  output  W-S+1  coarse binary word, weight 2^S
out_valid  output  1  one-cycle strobe: d_seg/d_msb updated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: d_seg=0, d_msb=0, out_valid=0, capture regs=0, capture-valid flag=0, all state bits s_i=0, LFSR=16'hACE1.
- Stage 1 (capture): on a clk edge with in_valid=1, register d_in, ms_en and en_dith, and set the capture-valid flag. Otherwise clear the flag; the data regs hold.
- Stage 2 (encode): on a clk edge with the capture-valid flag set:
  - compute from the captured values;
  - register d_seg and d_msb;
  - update s_i and advance the LFSR;
  - set out_valid=1.
  Otherwise out_valid=0, and outputs and states hold.
- Latency: 2 clk cycles from in_valid sampled to out_valid. Back-to-back samples every cycle are supported. No backpressure.
- Encode arithmetic: start with v_0 = x. For stage i = 0..S-1:
  - v_i[0]=0: t_i=0, v_{i+1} = v_i>>1.
  - v_i[0]=1 and (ms_en=0 or s_i=0): t_i=+1, v_{i+1} = (v_i-1)>>1.
  - v_i[0]=1 and ms_en=1 and s_i=1: t_i=-1, v_{i+1} = (v_i+1)>>1.
  - d_msb = v_S. Its maximum is 2^(W-S), which needs W-S+1 bits; intermediate v_i is W bits plus 1.
- Invariant: x = d_msb*2^S + sum(t_i*2^i), exact for every sample.
- State update, only on encode cycles with ms_en=1:
  - s_i toggles when v_i[0]=1.
  - When v_i[0]=0, s_i toggles only if dither is active and r_i=1.
  - ms_en=0 freezes all s_i. Re-enabling resumes from the frozen state.
- Dither bits: r_i = LFSR[i mod 16]. LFSR is 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. It shifts once per encode cycle with dither active; otherwise it holds.
- Reset mid-operation: in-flight captured samples are discarded, out_valid=0 immediately, and no out_valid is issued for pre-reset captures.
- Simultaneous in_valid and encode: normal pipelining. The new capture does not disturb the sample being encoded.
- x=0: all t_i=0, d_msb=0, states unchanged except dither toggles.

Optional Feature:
EF_SMSDAC_DITHER_EN:
- Defined: the LFSR is instantiated, and dither is active when the captured en_dith=1 and ms_en=1.
- Undefined: no LFSR registers; r_i is treated as 0; en_dith is captured but ignored. Output is identical to the defined build with en_dith=0.

Test Plan:
- Reset and latency: assert rst mid-stream with in_valid=1 -> d_seg=0, d_msb=0 and out_valid=0 asynchronously. After release, in_valid pulse at cycle n -> out_valid only at n+2.
- First-order alternation: W=8, S=3, ms_en=1, x=1 every cycle -> d_seg[1:0] = 01,10,01,10... d_seg[3:2] = 00,01,00,10... d_msb=0. Invariant holds each sample.
- Full-scale carry: ms_en=1, x=255 twice from reset -> first {t2,t1,t0}=+1,+1,+1 with d_msb=31. Second t0=-1, t1=0, t2=0 with d_msb=32, the 6-bit maximum.
- Bypass: ms_en=0, x=0xA5 -> t0=+1, t1=0, t2=+1, d_msb=20. Repeated samples give identical outputs and s_i stay frozen.
- Handshake gaps: in_valid pattern 1,0,0,1,1 -> out_valid pattern delayed 2 cycles. Outputs and s_i hold during gaps.
- Dither (macro defined): ms_en=1, en_dith=1, x=0 for 64 samples -> d_seg=0 and d_msb=0 throughout. s_i toggle per the LFSR golden model. With en_dith=0, s_i stay constant.
